transmit_buffer: RTL and testbench

//   SPART transmit path. Accepts a byte written by the processor over the

---
 rtl/transmit_buffer.sv | 135 +++++++++++++
 tb/tb_transmit_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/transmit_buffer.sv
// SPART transmit path: double-buffered byte writer that frames each byte as
// start(0), 8 data bits MSB first, stop(1) on TxD, one bit per baud enable.
module transmit_buffer (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       TxD,
   output logic       tbr,
   output logic       tx_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } tx_state_t;

   tx_state_t   state;
   tx_state_t   state_nx;
   logic [7:0]  hold_reg;
   logic [7:0]  hold_nx;
   logic        hold_full;
   logic        hold_full_nx;
   logic [7:0]  shift_reg;
   logic [7:0]  shift_nx;
   logic [2:0]  bit_cnt;
   logic [2:0]  bit_cnt_nx;
   logic        txd_nx;
   logic        wr;

   // Bus write decode, holding-register update and frame sequencing.
   always_comb begin
      wr           = iocs & ~iorw & (ioaddr == 2'b00);
      state_nx     = state;
      hold_nx      = hold_reg;
      hold_full_nx = hold_full;
      shift_nx     = shift_reg;
      bit_cnt_nx   = bit_cnt;

      // A full holding register drops the write; the processor polls tbr.
      if (wr && !hold_full) begin
         hold_nx      = databus;
         hold_full_nx = 1'b1;
      end else begin
         hold_nx      = hold_reg;
         hold_full_nx = hold_full;
      end

      case (state)
         IDLE: begin
            if (hold_full) begin
               shift_nx     = hold_reg;
               hold_full_nx = 1'b0;
               bit_cnt_nx   = 3'd0;
               state_nx     = START;
            end else begin
               state_nx = IDLE;
            end
         end
         START: begin
            if (enable) begin
               state_nx = DATA;
            end else begin
               state_nx = START;
            end
         end
         DATA: begin
            if (enable) begin
               shift_nx   = {shift_reg[6:0], 1'b0};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nx = STOP;
               end else begin
                  state_nx = DATA;
               end
            end else begin
               state_nx = DATA;
            end
         end
         STOP: begin
            if (enable) begin
               // Back-to-back frames: next start bit follows stop with no idle bit.
               if (hold_full) begin
                  shift_nx     = hold_reg;
                  hold_full_nx = 1'b0;
                  bit_cnt_nx   = 3'd0;
                  state_nx     = START;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               state_nx = STOP;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      case (state_nx)
         START:   txd_nx = 1'b0;
         DATA:    txd_nx = shift_nx[7];
         default: txd_nx = 1'b1;
      endcase
   end

   // State and registered outputs; outputs reflect the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hold_reg  <= 8'h00;
         hold_full <= 1'b0;
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd0;
         TxD       <= 1'b1;
         tbr       <= 1'b1;
         tx_busy   <= 1'b0;
      end else begin
         state     <= state_nx;
         hold_reg  <= hold_nx;
         hold_full <= hold_full_nx;
         shift_reg <= shift_nx;
         bit_cnt   <= bit_cnt_nx;
         TxD       <= txd_nx;
         tbr       <= ~hold_full_nx;
         tx_busy   <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_transmit_buffer.sv
// Directed bench for transmit_buffer: frame bit order, double buffering,
// dropped writes, bus decode and asynchronous reset.
module tb_transmit_buffer;

   localparam int GAP = 15;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] bus_val;
   wire  [7:0] databus;
   logic       TxD;
   logic       tbr;
   logic       tx_busy;

   int checks;
   int failures;

   assign databus = bus_val;

   transmit_buffer dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .databus (databus),
      .TxD     (TxD),
      .tbr     (tbr),
      .tx_busy (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_cycle(input logic cs, input logic rw, input logic [1:0] addr,
                            input logic [7:0] data);
      @(negedge clk);
      iocs    = cs;
      iorw    = rw;
      ioaddr  = addr;
      bus_val = data;
      @(negedge clk);
      iocs    = 1'b0;
      iorw    = 1'b1;
      ioaddr  = 2'b00;
   endtask

   task automatic tick();
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic wait_tbr(input string tag);
      int n;
      n = 0;
      while (tbr !== 1'b1 && n < 100) begin
         @(negedge clk);
         n = n + 1;
      end
      check_eq(tag, {7'd0, tbr}, 8'h01);
   endtask

   // Checks the 10 frame bits (each sampled just before its enable), then the
   // line state right after the stop tick.
   task automatic expect_frame(input string tag, input logic [7:0] b,
                               input logic after_txd, input logic after_busy);
      logic exp;
      for (int i = 0; i < 10; i++) begin
         repeat (GAP) @(negedge clk);
         if (i == 0) exp = 1'b0;
         else if (i == 9) exp = 1'b1;
         else exp = b[8-i];
         check_eq($sformatf("%s_bit%0d", tag, i), {7'd0, TxD}, {7'd0, exp});
         tick();
      end
      check_eq({tag, "_after_txd"}, {7'd0, TxD}, {7'd0, after_txd});
      check_eq({tag, "_after_busy"}, {7'd0, tx_busy}, {7'd0, after_busy});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      enable   = 1'b0;
      iocs     = 1'b0;
      iorw     = 1'b1;
      ioaddr   = 2'b00;
      bus_val  = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_txd", {7'd0, TxD}, 8'h01);
      check_eq("rst_tbr", {7'd0, tbr}, 8'h01);
      check_eq("rst_busy", {7'd0, tx_busy}, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      // Single frame 0xA5 with tbr latency
      bus_cycle(1'b1, 1'b0, 2'b00, 8'hA5);
      check_eq("a5_tbr_low", {7'd0, tbr}, 8'h00);
      @(negedge clk);
      check_eq("a5_tbr_back", {7'd0, tbr}, 8'h01);
      check_eq("a5_busy", {7'd0, tx_busy}, 8'h01);
      check_eq("a5_start_now", {7'd0, TxD}, 8'h00);
      expect_frame("a5", 8'hA5, 1'b1, 1'b0);

      // Back-to-back 0x3C then 0xC3
      bus_cycle(1'b1, 1'b0, 2'b00, 8'h3C);
      wait_tbr("3c_tbr_wait");
      bus_cycle(1'b1, 1'b0, 2'b00, 8'hC3);
      check_eq("c3_tbr_low", {7'd0, tbr}, 8'h00);
      expect_frame("3c", 8'h3C, 1'b0, 1'b1);
      expect_frame("c3", 8'hC3, 1'b1, 1'b0);

      // 0x33 written while holding register full must be dropped
      bus_cycle(1'b1, 1'b0, 2'b00, 8'h11);
      wait_tbr("11_tbr_wait");
      bus_cycle(1'b1, 1'b0, 2'b00, 8'h22);
      check_eq("22_tbr_low", {7'd0, tbr}, 8'h00);
      bus_cycle(1'b1, 1'b0, 2'b00, 8'h33);
      check_eq("33_tbr_low", {7'd0, tbr}, 8'h00);
      expect_frame("11", 8'h11, 1'b0, 1'b1);
      expect_frame("22", 8'h22, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         repeat (GAP) @(negedge clk);
         tick();
         check_eq("no33_txd", {7'd0, TxD}, 8'h01);
         check_eq("no33_busy", {7'd0, tx_busy}, 8'h00);
      end

      // Non-write bus cycles are ignored
      bus_cycle(1'b0, 1'b0, 2'b00, 8'hFF);
      check_eq("nocs_tbr", {7'd0, tbr}, 8'h01);
      check_eq("nocs_bus", databus, 8'hFF);
      bus_cycle(1'b1, 1'b1, 2'b00, 8'hFF);
      check_eq("read_tbr", {7'd0, tbr}, 8'h01);
      bus_cycle(1'b1, 1'b0, 2'b01, 8'hFF);
      check_eq("addr1_tbr", {7'd0, tbr}, 8'h01);
      check_eq("addr1_bus", databus, 8'hFF);
      for (int i = 0; i < 2; i++) begin
         repeat (GAP) @(negedge clk);
         tick();
         check_eq("ignored_txd", {7'd0, TxD}, 8'h01);
         check_eq("ignored_busy", {7'd0, tx_busy}, 8'h00);
      end

      // Async reset during data bit 4 of 0x0F, then a clean 0x81 frame
      bus_cycle(1'b1, 1'b0, 2'b00, 8'h0F);
      for (int i = 0; i < 5; i++) begin
         repeat (GAP) @(negedge clk);
         tick();
      end
      check_eq("0f_busy_pre", {7'd0, tx_busy}, 8'h01);
      #2 rst = 1'b1;
      #1;
      check_eq("async_txd", {7'd0, TxD}, 8'h01);
      check_eq("async_tbr", {7'd0, tbr}, 8'h01);
      check_eq("async_busy", {7'd0, tx_busy}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_txd", {7'd0, TxD}, 8'h01);
      bus_cycle(1'b1, 1'b0, 2'b00, 8'h81);
      expect_frame("81", 8'h81, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
